load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
//
// PURPOSE
//  CPU-side initiator for the word-addressed data memory (w_enable/m_address/mw_data/mr_data, combinational
//  read, write on posedge clk). Turns byte/halfword/word load-store requests (LB/LBU/LH/LHU/LW/SB/SH/SW)
//  into word accesses; sub-word stores use a 2-cycle read-modify-write. Sits between the datapath's MEM stage and data memory.
//
// PARAMETERS
//  ADDR_W  32  byte-address width; word index presented on m_address, low 2 bits always driven 0
//
// PORTS
//  clk          in   1       clock, all state on posedge
//  reset        in   1       asynchronous, active-high
//  req          in   1       request strobe; accepted only when ready=1
//  we           in   1       1=store, 0=load
//  size         in   2       00=byte, 01=half, 10=word, 11=treated as word
//  sign_ext     in   1       loads only: 1=sign-extend (LB/LH), 0=zero-extend (LBU/LHU)
//  addr         in   ADDR_W  byte address
//  wdata        in   32      store data; byte in [7:0], half in [15:0]
//  ready        out  1       1 in IDLE only
//  done         out  1       one-cycle pulse when request completes
//  rdata        out  32      extended load result; held until next load completes
//  err          out  1       misaligned-access flag (MISALIGN_TRAP_EN only, else tied 0)
//  m_w_enable   out  1       memory write enable
//  m_address    out  ADDR_W  memory byte address, [1:0]=00
//  mw_data      out  32      memory write data
//  mr_data      in   32      memory read data (combinational from m_address)
//
// BEHAVIOUR
//  - Reset (async): state=IDLE, ready=1, done=0, rdata=0, err=0, m_w_enable=0, m_address=0, mw_data=0,
//    latched regs=0. Reset mid-access aborts at once; m_w_enable is decoded from state reg, drops with reset, no write occurs.
//  - Accept: req&&ready at edge T latches we,size,sign_ext,addr,wdata; ready=0 from T+1. req ignored when ready=0.
//  - FSM: IDLE -> LD (load) | ST (SW) | RD (SB/SH); LD -> DONE; ST -> DONE; RD -> WR -> DONE; DONE -> IDLE.
//  - LD: m_address={addr_q[ADDR_W-1:2],2'b00}; extracted/extended mr_data registered into rdata at end of LD.
//  - ST: m_w_enable=1, mw_data=wdata_q. RD: m_w_enable=0, mr_data latched into merge reg.
//  - WR: m_w_enable=1, mw_data=merge reg with target lane(s) replaced from wdata_q; other lanes unchanged.
//  - DONE: done=1 exactly one cycle; ready=1 again next cycle. Latency accept->done: load/SW 2 cycles, SB/SH 3.
//  - Outside LD/ST/RD/WR: m_address holds last value, mw_data holds last value, m_w_enable=0.
//  - Little-endian lanes: byte k = word[8k+7:8k], k=addr[1:0]; half at addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//  - Extension: byte -> 24 bits of bit7 (sign_ext=1) or zeros; half -> 16 bits of bit15 or zeros; word unchanged.
//  - rdata unchanged by stores; err updated only at DONE of each access.
//
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> IDLE goes straight to DONE,
//    no memory access (m_w_enable never 1), err=1 from DONE until next access's DONE, rdata unchanged.
//  MISALIGN_TRAP_EN undefined: offending low bits ignored (half uses addr[1], word uses addr[1:0]=00); err tied 0.
//
// TESTING
//  1 mem[0x10]=0x8899AABB; LW 0x10 -> done at T+2, rdata=0x8899AABB, m_w_enable never 1.
//  2 same word; LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
//  3 SB 0x11 wdata=0x12345677 -> one write, mem[0x10]=0x8899 77BB (0x889977BB), done at T+3; SH 0x12 wdata=0x0000CAFE -> 0xCAFE77BB.
//  4 req held high through busy cycles -> second request accepted only on cycle after done; back-to-back SW/LW same addr returns written value.
//  5 reset asserted during WR of SB -> m_w_enable drops same cycle, memory word unchanged, ready=1, rdata=0.
//  6 LW 0x12: MISALIGN_TRAP_EN -> done at T+1, err=1, no memory access; without -> reads word 0x10, err=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit.
//   Request side : req, we, size, sign_ext, addr, wdata -> LSU
//                  ready, done, rdata, err            <- LSU
//   Memory side  : m_w_enable, m_address, mw_data     <- LSU
//                  mr_data                            -> LSU
// Modports:
//   master : the environment (datapath MEM stage plus data memory)
//   slave  : the load/store unit itself
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic              m_w_enable;
   logic [ADDR_W-1:0] m_address;
   logic [31:0]       mw_data;
   logic [31:0]       mr_data;

   modport master (
      output req, we, size, sign_ext, addr, wdata, mr_data,
      input  ready, done, rdata, err, m_w_enable, m_address, mw_data
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mr_data,
      output ready, done, rdata, err, m_w_enable, m_address, mw_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into word
// accesses on a word-addressed data memory with combinational read and
// write on posedge clk. Sub-word stores use a read-modify-write pair.
//
// Ports:
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous, active-high
//   bus    slave modport of load_store_unit_if (request + memory signals)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no memory access, err=1). Without it the offending low address
// bits are ignored and err is tied 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready=1, waiting for req
// LD    | load: word address on bus, result registered into rdata
// ST    | full-word store: write wdata
// RD    | sub-word store: read old word into merge register
// WR    | sub-word store: write merged word
// DONE  | done=1 for one cycle
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input logic             clk,
   input logic             reset,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD,
      S_ST,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [1:0]        size_q;
   logic              sign_ext_q;
   logic [1:0]        lane_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] m_address_q;
   logic [31:0]       mw_hold_q;
   logic [31:0]       mw_data_c;
   logic              accept;
   logic              misalign_in;

   // Pick the addressed lane out of a word and extend it.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   extract = {{24{sx & b[7]}}, b};
         2'b01:   extract = {{16{sx & h[15]}}, h};
         default: extract = w;
      endcase
   endfunction

   // Replace the target lane(s) of the old word with store data.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [1:0] lane, input logic [1:0] sz);
      logic [31:0] r;
      r = old;
      if (sz == 2'b00)
         r[{lane, 3'b000} +: 8] = wd[7:0];
      else if (lane[1])
         r[31:16] = wd[15:0];
      else
         r[15:0] = wd[15:0];
      return r;
   endfunction

   assign accept = bus.req && (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
   logic err_q;
   assign misalign_in = ((bus.size == 2'b01) && bus.addr[0]) ||
                        (bus.size[1] && (bus.addr[1:0] != 2'b00));
   assign bus.err     = err_q;
`else
   assign misalign_in = 1'b0;
   assign bus.err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         size_q      <= 2'b00;
         sign_ext_q  <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= '0;
         merge_q     <= '0;
         rdata_q     <= '0;
         m_address_q <= '0;
         mw_hold_q   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            size_q     <= bus.size;
            sign_ext_q <= bus.sign_ext;
            lane_q     <= bus.addr[1:0];
            wdata_q    <= bus.wdata;
            // A trapped access never touches memory, so the address holds.
            if (!misalign_in)
               m_address_q <= {bus.addr[ADDR_W-1:2], 2'b00};
         end
         if (state == S_LD)
            rdata_q <= extract(bus.mr_data, lane_q, size_q, sign_ext_q);
         if (state == S_RD)
            merge_q <= bus.mr_data;
         if ((state == S_ST) || (state == S_WR))
            mw_hold_q <= mw_data_c;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // err follows the access that is entering DONE; only the IDLE->DONE
   // shortcut is a trap, every other path into DONE is a clean access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if ((state_next == S_DONE) && (state != S_DONE))
         err_q <= (state == S_IDLE) ? misalign_in : 1'b0;
   end
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (misalign_in)
                  state_next = S_DONE;
               else if (!bus.we)
                  state_next = S_LD;
               else if (bus.size[1])
                  state_next = S_ST;
               else
                  state_next = S_RD;
            end
         end
         S_LD:    state_next = S_DONE;
         S_ST:    state_next = S_DONE;
         S_RD:    state_next = S_WR;
         S_WR:    state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      mw_data_c = mw_hold_q;
      if (state == S_ST)
         mw_data_c = wdata_q;
      else if (state == S_WR)
         mw_data_c = merge(merge_q, wdata_q, lane_q, size_q);
   end

   // Write enable is decoded straight from the state register so that
   // an asserted reset kills an in-flight write in the same cycle.
   assign bus.m_w_enable = (state == S_ST) || (state == S_WR);
   assign bus.m_address  = m_address_q;
   assign bus.mw_data    = mw_data_c;
   assign bus.ready      = (state == S_IDLE);
   assign bus.done       = (state == S_DONE);
   assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized
// load/store traffic against a behavioural memory/result model.
module tb_load_store_unit;

   logic clk;
   logic reset;

   load_store_unit_if #(.ADDR_W(32)) bus_if ();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory seen by the DUT, and the model's view of it.
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   int          wr_count = 0;

   assign bus_if.mr_data = mem[bus_if.m_address[7:2]];

   always @(posedge clk) begin
      if (bus_if.m_w_enable) begin
         mem[bus_if.m_address[7:2]] <= bus_if.mw_data;
         wr_count <= wr_count + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] model_load(input logic [31:0] word, input int a,
                                              input int sz, input bit sx);
      logic [31:0] v;
      int sh;
      if (sz == 0) begin
         sh = 8 * (a % 4);
         v  = (word >> sh) & 32'hFF;
         if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         sh = 8 * (a & 2);
         v  = (word >> sh) & 32'hFFFF;
         if (sx && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input int a, input int sz);
      logic [31:0] mask;
      int sh;
      if (sz == 0) begin
         sh   = 8 * (a % 4);
         mask = 32'hFF << sh;
         return (old & ~mask) | ((wd & 32'hFF) << sh);
      end else if (sz == 1) begin
         sh   = 8 * (a & 2);
         mask = 32'hFFFF << sh;
         return (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   function automatic bit model_misaligned(input int a, input int sz);
`ifdef MISALIGN_TRAP_EN
      return ((sz == 1) && (a % 2 != 0)) || ((sz >= 2) && (a % 4 != 0));
`else
      return 1'b0;
`endif
   endfunction

   // Expectations for the access currently in flight.
   bit          active   = 1'b0;
   bit          in_reset = 1'b1;
   int          k        = 0;
   int          lat      = 0;
   logic [31:0] exp_rd;
   logic        exp_er;
   int          exp_wr;
   int          wr_base;
   int          tgt;
   logic [31:0] prev_rd  = 32'h0;
   logic        prev_er  = 1'b0;

   // Called at the accepting edge; derives everything from the request.
   task automatic model_accept();
      int a, sz;
      bit sx, st, mis;
      a   = int'(bus_if.addr[7:0]);
      sz  = int'(bus_if.size);
      sx  = bus_if.sign_ext;
      st  = bus_if.we;
      mis = model_misaligned(a, sz);
      tgt = a / 4;
      exp_rd = prev_rd;
      exp_er = mis;
      exp_wr = 0;
      if (mis) begin
         lat = 1;
      end else if (!st) begin
         lat    = 2;
         exp_rd = model_load(ref_mem[tgt], a, sz, sx);
      end else begin
         lat          = (sz >= 2) ? 2 : 3;
         exp_wr       = 1;
         ref_mem[tgt] = model_store(ref_mem[tgt], bus_if.wdata, a, sz);
      end
      wr_base = wr_count;
      k       = 0;
      active  = 1'b1;
   endtask

   // Single compare process: checks DUT outputs on every falling edge.
   always @(negedge clk) begin
      if (!in_reset) begin
         if (active) begin
            k++;
            if (k <= lat) begin
               check("ready_busy", bus_if.ready, 1'b0);
               check("done", bus_if.done, (k == lat));
            end else begin
               check("ready_after", bus_if.ready, 1'b1);
               check("done_after", bus_if.done, 1'b0);
               check("write_count", wr_count - wr_base, exp_wr);
               check("mem_word", mem[tgt], ref_mem[tgt]);
               prev_rd = exp_rd;
               prev_er = exp_er;
               active  = 1'b0;
            end
            check("rdata", bus_if.rdata, (k >= lat) ? exp_rd : prev_rd);
            check("err", bus_if.err, (k >= lat) ? exp_er : prev_er);
         end else begin
            check("ready_idle", bus_if.ready, 1'b1);
            check("done_idle", bus_if.done, 1'b0);
            check("rdata_idle", bus_if.rdata, prev_rd);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input bit we, input int sz, input bit sx, input int a,
                        input logic [31:0] wd);
      bus_if.req      = 1'b1;
      bus_if.we       = we;
      bus_if.size     = sz[1:0];
      bus_if.sign_ext = sx;
      bus_if.addr     = a;
      bus_if.wdata    = wd;
   endtask

   task automatic accept_edge();
      @(posedge clk);
      model_accept();
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (!active) break;
      end
      if (active) begin
         check("op_timeout", 32'd1, 32'd0);
         active = 1'b0;
      end
   endtask

   task automatic op(input bit we, input int sz, input bit sx, input int a,
                     input logic [31:0] wd);
      drive(we, sz, sx, a, wd);
      accept_edge();
      #1 bus_if.req = 1'b0;
      wait_done();
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem[idx]     = v;
      ref_mem[idx] = v;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int wbase;
      for (int i = 0; i < 64; i++) set_word(i, $urandom);
      bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.size = 2'b00;
      bus_if.sign_ext = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", bus_if.ready, 1'b1);
      check("rst_done", bus_if.done, 1'b0);
      check("rst_rdata", bus_if.rdata, 32'h0);
      check("rst_err", bus_if.err, 1'b0);
      check("rst_mwe", bus_if.m_w_enable, 1'b0);
      check("rst_maddr", bus_if.m_address, 32'h0);
      check("rst_mwdata", bus_if.mw_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1 in_reset = 1'b0;

      // Word load, then sub-word loads of the same word.
      set_word(4, 32'h8899_AABB);
      wbase = wr_count;
      op(1'b0, 2, 1'b0, 32'h10, 32'h0);
      check("lw_lit", bus_if.rdata, 32'h8899_AABB);
      check("lw_nowrite", wr_count - wbase, 0);
      op(1'b0, 0, 1'b1, 32'h13, 32'h0);
      check("lb_lit", bus_if.rdata, 32'hFFFF_FF88);
      op(1'b0, 0, 1'b0, 32'h13, 32'h0);
      check("lbu_lit", bus_if.rdata, 32'h0000_0088);
      op(1'b0, 1, 1'b1, 32'h12, 32'h0);
      check("lh_lit", bus_if.rdata, 32'hFFFF_8899);
      op(1'b0, 1, 1'b0, 32'h10, 32'h0);
      check("lhu_lit", bus_if.rdata, 32'h0000_AABB);

      // Read-modify-write stores; rdata must not move.
      wbase = wr_count;
      op(1'b1, 0, 1'b0, 32'h11, 32'h1234_5677);
      check("sb_lit", mem[4], 32'h8899_77BB);
      check("sb_one_write", wr_count - wbase, 1);
      check("sb_rdata_kept", bus_if.rdata, 32'h0000_AABB);
      op(1'b1, 1, 1'b0, 32'h12, 32'h0000_CAFE);
      check("sh_lit", mem[4], 32'hCAFE_77BB);

      // Misaligned word load.
      wbase = wr_count;
      op(1'b0, 2, 1'b0, 32'h12, 32'h0);
`ifdef MISALIGN_TRAP_EN
      check("mis_err", bus_if.err, 1'b1);
      check("mis_rdata_kept", bus_if.rdata, 32'h0000_AABB);
`else
      check("mis_rdata", bus_if.rdata, 32'hCAFE_77BB);
      check("mis_err", bus_if.err, 1'b0);
`endif
      check("mis_nowrite", wr_count - wbase, 0);

      // req held high: second request only taken after done.
      drive(1'b1, 2, 1'b0, 32'h20, 32'hDEAD_BEEF);
      accept_edge();
      #1 drive(1'b0, 2, 1'b0, 32'h20, 32'h0);
      wait_done();
      accept_edge();
      #1 bus_if.req = 1'b0;
      wait_done();
      check("b2b_lit", bus_if.rdata, 32'hDEAD_BEEF);

      // Reset in the write cycle of a byte store.
      set_word(4, 32'h8899_AABB);
      drive(1'b1, 0, 1'b0, 32'h11, 32'h0000_00AB);
      accept_edge();
      #1 bus_if.req = 1'b0;
      @(posedge clk);
      #2;
      check("wr_phase_mwe", bus_if.m_w_enable, 1'b1);
      in_reset = 1'b1;
      active   = 1'b0;
      reset    = 1'b1;
      #1;
      check("abort_mwe", bus_if.m_w_enable, 1'b0);
      check("abort_ready", bus_if.ready, 1'b1);
      check("abort_rdata", bus_if.rdata, 32'h0);
      check("abort_done", bus_if.done, 1'b0);
      ref_mem[4] = 32'h8899_AABB;
      @(posedge clk);
      #1;
      check("abort_mem", mem[4], 32'h8899_AABB);
      @(negedge clk);
      reset   = 1'b0;
      prev_rd = 32'h0;
      prev_er = 1'b0;
      #1 in_reset = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), $urandom);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
